// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The requester drives the master side; the subtractor sits on the slave side.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output start, A, B, bin,
        input  busy, done, diff, borrow
    );

    modport slave (
        input  start, A, B, bin,
        output busy, done, diff, borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = A - B - bin over WIDTH cycles, LSB first, with a
// start/done handshake. Each cycle is one full-subtract slice built from two half-subtracts.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CntW-1:0]  cnt_q;
    logic             br_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             hs1_d;
    logic             hs1_b;
    logic             hs2_d;
    logic             hs2_b;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    // First half-subtract handles a - b, the second folds in the stored borrow.
    always_comb begin
        hs1_d    = a_q[0] ^ b_q[0];
        hs1_b    = ~a_q[0] & b_q[0];
        hs2_d    = hs1_d ^ br_q;
        hs2_b    = ~hs1_d & br_q;
        br_next  = hs1_b | hs2_b;
        res_next = {hs2_d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        br_q    <= bus.bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_next;
                    br_q  <= br_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == LastBit) begin
                        diff_q   <= res_next;
                        borrow_q <= br_next;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
endmodule
